// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter that shares one stack between NREQ requesters.
// Each granted request becomes exactly one stack command. The arbiter then waits for
// the stack's results and returns rdata/err with a one-cycle done pulse.
//
// Optional build macro: STACK_ARB_PRECHECK_EN
//   When defined, a push on a full stack or a pop on an empty stack is refused
//   without being issued to the stack. The arbiter goes straight to DONE with err=1.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req            per-requester request, held until its done pulse
//   req_op         2-bit op per requester: 00 nop, 01 clear, 10 push, 11 pop
//   req_wdata      DW-bit push data per requester
//   gnt            one-hot grant, high from ISSUE through DONE
//   done           one-cycle completion pulse to the granted requester
//   rdata, err     popped data and error status, valid with done
//   err_cnt        saturating count of errored ops
//   busy           high whenever the FSM is not idle
//   stk_cmd        command to the stack
//   stk_data_in    push data to the stack
//   stk_data_out   pop data from the stack
//   stk_full       stack full flag
//   stk_empty      stack empty flag
//   stk_error      stack error flag
module stack_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [DW*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [DW-1:0]        rdata,
  output logic                 err,
  output logic [7:0]           err_cnt,
  output logic                 busy,
  output logic [1:0]           stk_cmd,
  output logic [DW-1:0]        stk_data_in,
  input  logic [DW-1:0]        stk_data_out,
  input  logic                 stk_full,
  input  logic                 stk_empty,
  input  logic                 stk_error
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            busy_q, busy_d;
  logic [1:0]      stk_cmd_q, stk_cmd_d;
  logic [DW-1:0]   stk_data_in_q, stk_data_in_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [1:0]      op_q, op_d;
  logic            err_set;

  // Round-robin pick: rotate req so the rr pointer sits at bit 0, take the first set bit
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              pick_vld;
  logic [PW-1:0]     pick_idx;
  logic [1:0]        pick_op;
  logic [DW-1:0]     pick_wdata;

  always_comb begin
    req_dbl  = {req, req};
    req_rot  = NREQ'(req_dbl >> rr_q);
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!pick_vld && req_rot[k]) begin
        pick_vld = 1'b1;
        pick_idx = PW'((32'(rr_q) + k) % NREQ);
      end
    end
    pick_op    = OP_NOP;
    pick_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == PW'(i)) begin
        pick_op    = req_op[2*i +: 2];
        pick_wdata = req_wdata[DW*i +: DW];
      end
    end
  end

`ifndef STACK_ARB_PRECHECK_EN
  // Flags are consulted only by the precheck path
  logic unused_flags;
  assign unused_flags = stk_full ^ stk_empty;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    done_d        = done_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    err_cnt_d     = err_cnt_q;
    stk_cmd_d     = stk_cmd_q;
    stk_data_in_d = stk_data_in_q;
    rr_d          = rr_q;
    gidx_d        = gidx_q;
    op_d          = op_q;
    err_set       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gidx_d = pick_idx;
          op_d   = pick_op;
          gnt_d  = NREQ'(1) << pick_idx;
`ifdef STACK_ARB_PRECHECK_EN
          // Refuse ops the stack is known to reject; nothing is sent to the stack
          if ((pick_op == OP_PUSH && stk_full) || (pick_op == OP_POP && stk_empty)) begin
            done_d  = NREQ'(1) << pick_idx;
            err_d   = 1'b1;
            err_set = 1'b1;
            state_d = S_DONE;
          end else
`endif
          begin
            stk_cmd_d     = pick_op;
            stk_data_in_d = pick_wdata;
            state_d       = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        stk_cmd_d = OP_NOP;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        done_d  = gnt_q;
        state_d = S_DONE;
        // Only push/pop can legitimately fail; nop/clear always report success
        if (op_q == OP_PUSH || op_q == OP_POP) begin
          err_d   = stk_error;
          err_set = stk_error;
        end else begin
          err_d = 1'b0;
        end
        if (op_q == OP_POP && !stk_error) begin
          rdata_d = stk_data_out;
        end
      end
      S_DONE: begin
        done_d  = '0;
        gnt_d   = '0;
        rr_d    = (gidx_q == PW'(NREQ-1)) ? '0 : gidx_q + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (err_set && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      gnt_q         <= '0;
      done_q        <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
      busy_q        <= 1'b0;
      stk_cmd_q     <= OP_NOP;
      stk_data_in_q <= '0;
      rr_q          <= '0;
      gidx_q        <= '0;
      op_q          <= OP_NOP;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
      busy_q        <= busy_d;
      stk_cmd_q     <= stk_cmd_d;
      stk_data_in_q <= stk_data_in_d;
      rr_q          <= rr_d;
      gidx_q        <= gidx_d;
      op_q          <= op_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = busy_q;
  assign stk_cmd     = stk_cmd_q;
  assign stk_data_in = stk_data_in_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: stack device model plus a queue-based reference of
// the arbiter's observable behaviour (winner order, rdata, err, err_cnt, latency).
module tb_stack_arbiter;

  localparam int NREQ  = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

`ifdef STACK_ARB_PRECHECK_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [2*NREQ-1:0]    req_op = '0;
  logic [DW*NREQ-1:0]   req_wdata = '0;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [DW-1:0]        rdata;
  logic                 err;
  logic [7:0]           err_cnt;
  logic                 busy;
  logic [1:0]           stk_cmd;
  logic [DW-1:0]        stk_data_in;
  logic [DW-1:0]        stk_data_out = '0;
  logic                 stk_full = 1'b0;
  logic                 stk_empty = 1'b1;
  logic                 stk_error = 1'b0;

  stack_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err), .err_cnt(err_cnt), .busy(busy),
    .stk_cmd(stk_cmd), .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_error(stk_error)
  );

  always #5 clk = ~clk;

  // Stack device: executes cmd at posedge, flags settle at negedge
  logic [DW-1:0] smem [DEPTH];
  int            sp = 0;
  logic          s_err = 1'b0;

  always @(posedge clk) begin
    case (stk_cmd)
      OP_CLR: begin sp <= 0; s_err <= 1'b0; end
      OP_PUSH: begin
        if (sp == DEPTH) s_err <= 1'b1;
        else begin smem[sp] <= stk_data_in; sp <= sp + 1; s_err <= 1'b0; end
      end
      OP_POP: begin
        if (sp == 0) s_err <= 1'b1;
        else begin stk_data_out <= smem[sp-1]; sp <= sp - 1; s_err <= 1'b0; end
      end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    stk_full  <= (sp == DEPTH);
    stk_empty <= (sp == 0);
    stk_error <= s_err;
  end

  // Reference model
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_rdata;
  logic [7:0]    m_errcnt;
  int            m_rr;

  int n_chk = 0;
  int n_err = 0;
  logic [NREQ-1:0] seq_log[$];
  logic            last_err;
  logic [DW-1:0]   last_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_rdata  = '0;
    m_errcnt = '0;
    m_rr     = 0;
  endtask

  task automatic m_apply(input logic [1:0] op, input logic [DW-1:0] wd,
                         output logic e, output bit skip);
    e = 1'b0; skip = 1'b0;
    case (op)
      OP_CLR: m_q.delete();
      OP_PUSH: if (m_q.size() >= DEPTH) begin e = 1'b1; skip = PRE; end
               else m_q.push_back(wd);
      OP_POP:  if (m_q.size() == 0) begin e = 1'b1; skip = PRE; end
               else m_rdata = m_q.pop_back();
      default: ;
    endcase
    if (e && m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; req_op = '0; req_wdata = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_stk_cmd", 32'(stk_cmd), 0);
    chk("rst_stk_data_in", 32'(stk_data_in), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
  endtask

  // Hold requests in mask; serve until all done (n_serv=0) or n_serv grants with re-arming
  task automatic run_round(input logic [NREQ-1:0] mask, input logic [2*NREQ-1:0] ops,
                           input logic [DW*NREQ-1:0] wds, input int n_serv);
    logic [NREQ-1:0] pend;
    int   served, w, n, lat, rearm;
    bit   got, skip;
    logic e;
    pend = mask; served = 0; rearm = -1;
    req_op = ops; req_wdata = wds; req = mask;
    while (pend != '0 && (n_serv == 0 || served < n_serv)) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && pend[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
      m_apply(ops[2*w +: 2], wds[DW*w +: DW], e, skip);
      lat = (skip ? 1 : 3) + (served == 0 ? 0 : 1);
      n = 0; got = 1'b0;
      while (!got && n < 12) begin
        @(posedge clk); #1; n++;
        if (rearm >= 0) begin req[rearm] = 1'b1; rearm = -1; end
        if (done != '0) got = 1'b1;
      end
      if (!got) begin
        chk("done_timeout", 0, 1);
        req = '0;
        return;
      end
      seq_log.push_back(done);
      chk("latency", 32'(n), 32'(lat));
      chk("done_winner", 32'(done), 32'(1) << w);
      chk("gnt_winner", 32'(gnt), 32'(1) << w);
      chk("err", 32'(err), 32'(e));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
      last_err = err; last_rdata = rdata;
      req[w] = 1'b0;
      if (n_serv > 0) rearm = w; else pend[w] = 1'b0;
      m_rr = (w + 1) % NREQ;
      served++;
    end
    @(posedge clk); #1;
    req = '0;
    chk("done_pulse_end", 32'(done), 0);
    chk("gnt_release", 32'(gnt), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  task automatic run_one(input int idx, input logic [1:0] op, input logic [DW-1:0] wd);
    logic [2*NREQ-1:0]  ops;
    logic [DW*NREQ-1:0] wds;
    ops = '0; wds = '0;
    ops[2*idx +: 2]  = op;
    wds[DW*idx +: DW] = wd;
    run_round(NREQ'(1) << idx, ops, wds, 0);
  endtask

  typedef struct {
    int         idx;
    logic [1:0] op;
    logic [7:0] wd;
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e;
    bit   skip;
    m_reset();
    do_reset();

    // Clear: cmd for exactly one cycle, done at P2
    req_op = {OP_NOP, OP_CLR}; req = 2'b01;
    m_apply(OP_CLR, '0, e, skip);
    @(posedge clk); #1;
    chk("t1_cmd_p0", 32'(stk_cmd), 32'(OP_CLR));
    chk("t1_gnt_p0", 32'(gnt), 1);
    chk("t1_busy_p0", 32'(busy), 1);
    @(posedge clk); #1;
    chk("t1_cmd_p1", 32'(stk_cmd), 0);
    chk("t1_done_p1", 32'(done), 0);
    @(posedge clk); #1;
    chk("t1_done_p2", 32'(done), 1);
    chk("t1_err_p2", 32'(err), 0);
    chk("t1_empty", 32'(stk_empty), 1);
    req = '0;
    @(posedge clk); #1;
    chk("t1_done_p3", 32'(done), 0);
    chk("t1_gnt_p3", 32'(gnt), 0);
    m_rr = 1;

    // Simultaneous pushes: requester 0 wins after reset
    do_reset();
    seq_log.delete();
    run_round(2'b11, {OP_PUSH, OP_PUSH}, {8'h02, 8'h01}, 0);
    chk("t2_order0", 32'(seq_log[0]), 1);
    chk("t2_order1", 32'(seq_log[1]), 2);
    run_one(0, OP_POP, '0);
    chk("t2_pop0", 32'(last_rdata), 32'h02);
    run_one(0, OP_POP, '0);
    chk("t2_pop1", 32'(last_rdata), 32'h01);

    // Pop on empty stack
    req_op = {OP_NOP, OP_POP}; req = 2'b01;
    m_apply(OP_POP, '0, e, skip);
    @(posedge clk); #1;
`ifdef STACK_ARB_PRECHECK_EN
    chk("t3_cmd_pre", 32'(stk_cmd), 0);
    chk("t3_done_pre", 32'(done), 1);
    chk("t3_gnt_pre", 32'(gnt), 1);
    chk("t3_err_pre", 32'(err), 1);
    chk("t3_errcnt_pre", 32'(err_cnt), 1);
    chk("t3_rdata_pre", 32'(rdata), 32'h01);
    req = '0;
    @(posedge clk); #1;
    chk("t3_done_end", 32'(done), 0);
    chk("t3_gnt_end", 32'(gnt), 0);
`else
    chk("t3_cmd_p0", 32'(stk_cmd), 32'(OP_POP));
    @(posedge clk); #1;
    chk("t3_cmd_p1", 32'(stk_cmd), 0);
    @(posedge clk); #1;
    chk("t3_done_p2", 32'(done), 1);
    chk("t3_err", 32'(err), 1);
    chk("t3_errcnt", 32'(err_cnt), 1);
    chk("t3_rdata", 32'(rdata), 32'h01);
    req = '0;
    @(posedge clk); #1;
    chk("t3_done_end", 32'(done), 0);
`endif
    m_rr = 1;

    // Table of single ops with hand-derived results
    tbl[0] = '{0, OP_PUSH, 8'hAA, 1'b0, 8'h01};
    tbl[1] = '{1, OP_PUSH, 8'h55, 1'b0, 8'h01};
    tbl[2] = '{0, OP_POP,  8'h00, 1'b0, 8'h55};
    tbl[3] = '{1, OP_NOP,  8'h00, 1'b0, 8'h55};
    tbl[4] = '{1, OP_POP,  8'h00, 1'b0, 8'hAA};
    tbl[5] = '{0, OP_POP,  8'h00, 1'b1, 8'hAA};
    tbl[6] = '{0, OP_PUSH, 8'h7E, 1'b0, 8'hAA};
    tbl[7] = '{1, OP_CLR,  8'h00, 1'b0, 8'hAA};
    tbl[8] = '{1, OP_POP,  8'h00, 1'b1, 8'hAA};
    tbl[9] = '{0, OP_NOP,  8'h00, 1'b0, 8'hAA};
    for (int i = 0; i < 10; i++) begin
      run_one(tbl[i].idx, tbl[i].op, tbl[i].wd);
      chk($sformatf("tbl%0d_err", i), 32'(last_err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_rdata", i), 32'(last_rdata), 32'(tbl[i].exp_rdata));
    end
    chk("tbl_errcnt", 32'(err_cnt), 3);

    // Fill to full, overflow push, then pop the last accepted value
    for (int i = 0; i < DEPTH; i++) run_one(0, OP_PUSH, 8'(8'h03 + i));
    chk("t4_full", 32'(stk_full), 1);
    run_one(0, OP_PUSH, 8'h0C);
    chk("t4_ovf_err", 32'(last_err), 1);
    chk("t4_ovf_errcnt", 32'(err_cnt), 4);
    run_one(1, OP_POP, '0);
    chk("t4_pop_last", 32'(last_rdata), 32'h0A);

    // Reset during ISSUE: stk_cmd drops asynchronously
    req_op = {OP_NOP, OP_PUSH}; req_wdata = {8'h00, 8'h99}; req = 2'b01;
    @(posedge clk); #1;
    chk("t5_issue_cmd", 32'(stk_cmd), 32'(OP_PUSH));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_issue_rst_cmd", 32'(stk_cmd), 0);
    chk("t5_issue_rst_gnt", 32'(gnt), 0);
    req = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    m_reset();

    // Reset during WAIT
    req_op = {OP_NOP, OP_PUSH}; req_wdata = {8'h00, 8'h77}; req = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_wait_gnt", 32'(gnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_cmd", 32'(stk_cmd), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    req = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_one(0, OP_NOP, '0);
    chk("t5_nop_err", 32'(last_err), 0);
    run_one(0, OP_CLR, '0);

    // Both requesters held with nops: grants must alternate
    seq_log.delete();
    run_round(2'b11, {OP_NOP, OP_NOP}, '0, 4);
    for (int i = 1; i < 4; i++)
      chk($sformatf("t6_alt%0d", i), 32'(seq_log[i] != seq_log[i-1]), 1);

    // Random rounds against the reference model
    for (int r = 0; r < 40; r++) begin
      logic [NREQ-1:0]    mask;
      logic [2*NREQ-1:0]  ops;
      logic [DW*NREQ-1:0] wds;
      int sel;
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        sel = $urandom_range(0, 9);
        ops[2*i +: 2] = (sel == 0) ? OP_NOP : (sel == 1) ? OP_CLR :
                        (sel < 6) ? OP_PUSH : OP_POP;
        wds[DW*i +: DW] = DW'($urandom);
      end
      run_round(mask, ops, wds, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
